demux4_buf: RTL and testbench
=============================

DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer offers a word this cycle.
REQ-005 in_ready  output  1  block accepts the offered word this cycle.
REQ-006 in_sel  input  2  destination channel (0-3) for the offered word.
REQ-007 in_data  input  WIDTH  offered word.
REQ-008 out_valid  output  4  bit k: channel k holds a word.
REQ-009 out_ready  input  4  bit k: consumer k takes the word this cycle.
REQ-010 out_data  output  4*WIDTH  channel k word at bits [k*WIDTH +: WIDTH].
REQ-011 acc_cnt  output  32  channel k accept count at bits [k*8 +: 8].

Function
REQ-012 Each channel SHALL own a one-entry holding register plus a valid flag; out_valid[k] and out_data slice k SHALL come directly from these registers.
REQ-013 in_ready SHALL be combinational: ~out_valid[in_sel] | out_ready[in_sel]; it SHALL NOT depend on in_valid.
REQ-014 Accept = in_valid & in_ready; on accept, channel in_sel SHALL load in_data and set valid at the next edge (1-cycle latency, no combinational in_data->out_data path).
REQ-015 Drain = out_valid[k] & out_ready[k]; on drain without refill, valid[k] SHALL clear at the next edge.
REQ-016 Drain and accept on the same channel in the same cycle: valid stays 1 and the new word is loaded (full throughput, 1 word/cycle/channel).
REQ-017 While out_valid[k]=1 and out_ready[k]=0, out_data slice k SHALL stay constant.
REQ-018 Channels SHALL be independent; any subset may drain in the same cycle as an accept to a different channel.
REQ-019 Full channel selected and not draining: in_ready=0; no state change; word stays with the producer.
REQ-020 in_sel and in_data SHALL be ignored when in_valid=0.
REQ-021 acc_cnt slice k SHALL increment by 1 on each accept to channel k, wrapping 255->0 without flag.
REQ-022 out_ready[k] with out_valid[k]=0 SHALL have no effect.

Reset
REQ-023 With reset high at a rising edge: all valid flags=0, all holding registers=0, all acc_cnt slices=0.
REQ-024 While reset is high, accepts and drains SHALL NOT update state; in_ready follows REQ-013 from current registers.
REQ-025 Reset mid-operation SHALL discard all held words; first accept possible in the cycle after reset deasserts.

Structure
REQ-026 Package demux_pkg SHALL hold NCH=4, CNT_W=8, and the 2-bit channel-select typedef.
REQ-027 Sub-module chan_slot (one-entry register, valid flag, 8-bit counter, load/drain inputs) SHALL be instantiated NCH times; top level holds only select decode and in_ready mux.

Verification
REQ-028 Reset then idle: out_valid=4'b0000, out_data=0, acc_cnt=0, in_ready=1 for every in_sel.
REQ-029 Send 8'hA5 to sel 2 with out_ready=0 -> next cycle out_valid=4'b0100, slice 2=8'hA5; second offer to sel 2 sees in_ready=0 and is held off; acc_cnt slice 2=1.
REQ-030 Channel 1 full, out_ready[1]=1, send 8'h3C to sel 1 same cycle -> in_ready=1, out_valid[1] stays 1, slice 1 becomes 8'h3C.
REQ-031 Back-to-back words 0,1,2,3 to sels 0,1,2,3 with out_ready=0 -> out_valid=4'b1111, slices hold 0..3; then out_ready=4'b1111 for one cycle -> out_valid=4'b0000.
REQ-032 256 accepts to channel 3 with out_ready[3]=1 -> acc_cnt slice 3 wraps to 0; other slices unchanged.
REQ-033 Channels 0 and 2 full, reset high for one edge -> out_valid=0, all counters 0, held words lost.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the four-channel demux buffer
package demux_pkg;
   localparam int NCH   = 4;
   localparam int CNT_W = 8;

   typedef logic [1:0] sel_t;
endpackage

// File: rtl/chan_slot.sv
// rtl/chan_slot.sv - one-entry holding register with valid flag and wrapping accept counter
module chan_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt
);

   // A load wins over a drain so a same-cycle drain+refill keeps the slot full.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         cnt   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         cnt   <= cnt + CNT_W'(1);
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux4_buf.sv
// rtl/demux4_buf.sv - routes one input stream into four independently drained one-entry slots
module demux4_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  sel_t                 in_sel,
   input  logic [WIDTH-1:0]     in_data,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [NCH*CNT_W-1:0] acc_cnt
);

   logic accept;
   logic [NCH-1:0] load;
   logic [NCH-1:0] drain;

   // Selected slot can take a word if empty or emptying this cycle.
   assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      assign load[k]  = accept & (in_sel == sel_t'(k));
      assign drain[k] = out_valid[k] & out_ready[k];

      chan_slot #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk      (clk),
         .reset    (reset),
         .load     (load[k]),
         .drain    (drain[k]),
         .load_data(in_data),
         .valid    (out_valid[k]),
         .data     (out_data[k*WIDTH +: WIDTH]),
         .cnt      (acc_cnt[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_demux4_buf.sv
// tb/tb_demux4_buf.sv - scoreboard bench for demux4_buf with directed and random traffic
module tb_demux4_buf;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_sel = 2'd0;
   logic [W-1:0]  in_data = '0;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready = 4'b0;
   logic [4*W-1:0] out_data;
   logic [31:0]   acc_cnt;

   demux4_buf #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .acc_cnt  (acc_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: each channel is a queue of words; front = word being held,
   // a second entry is the word accepted this cycle that lands at the next edge.
   logic [W-1:0] q [4][$];
   logic [7:0]   exp_cnt [4];
   logic [3:0]   pending = 4'b0;
   logic         exp_ready = 1'b1;
   logic         check_en = 1'b0;
   int           n_pass = 0;
   int           n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] r);
      @(posedge clk);
      #1;
      pending   = 4'b0;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      exp_ready = (q[s].size() == 0) || r[s];
      if (v && exp_ready && !reset) begin
         q[s].push_back(d);
         pending[s] = 1'b1;
         exp_cnt[s] = exp_cnt[s] + 8'd1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      pending   = 4'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 4'b0;
      exp_ready = (q[in_sel].size() == 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         exp_cnt[k] = 8'd0;
      end
      exp_ready = 1'b1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         for (int k = 0; k < 4; k++) begin
            int held;
            held = q[k].size() - int'(pending[k]);
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(held > 0));
            if (held > 0)
               chk($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]), 32'(q[k][0]));
            chk($sformatf("acc_cnt[%0d]", k), 32'(acc_cnt[k*8 +: 8]),
                32'(8'(exp_cnt[k] - 8'(pending[k]))));
            if (!reset && held > 0 && out_ready[k]) void'(q[k].pop_front());
         end
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
      do_reset();
      check_en = 1'b1;

      // Idle after reset: every channel empty and ready.
      for (int s = 0; s < 4; s++) cycle(1'b0, 2'(s), 8'hFF, 4'b0);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_acc_cnt", acc_cnt, 32'h0);

      // Single word parks in channel 2; a second offer is held off.
      cycle(1'b1, 2'd2, 8'hA5, 4'b0);
      cycle(1'b1, 2'd2, 8'h66, 4'b0);
      #1 chk("full_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      chk("full_valid", 32'(out_valid), 32'h4);
      chk("full_data2", 32'(out_data[23:16]), 32'hA5);
      chk("full_cnt2", 32'(acc_cnt[23:16]), 32'h1);

      // Drain and refill channel 1 in the same cycle.
      cycle(1'b1, 2'd1, 8'h11, 4'b0);
      cycle(1'b1, 2'd1, 8'h3C, 4'b0010);
      #1 chk("refill_ready", 32'(in_ready), 32'h1);
      cycle(1'b0, 2'd0, 8'h00, 4'b0);
      @(negedge clk);
      chk("refill_valid1", 32'(out_valid[1]), 32'h1);
      chk("refill_data1", 32'(out_data[15:8]), 32'h3C);

      // Fill all four back to back, then drain all at once.
      do_reset();
      for (int s = 0; s < 4; s++) cycle(1'b1, 2'(s), 8'(s), 4'b0);
      cycle(1'b0, 2'd0, 8'h00, 4'b0);
      @(negedge clk);
      chk("all_valid", 32'(out_valid), 32'hF);
      chk("all_data", out_data, 32'h03020100);
      cycle(1'b0, 2'd0, 8'h00, 4'b1111);
      cycle(1'b0, 2'd0, 8'h00, 4'b0);
      @(negedge clk);
      chk("all_drained", 32'(out_valid), 32'h0);

      // 256 accepts to channel 3 wrap its counter.
      do_reset();
      for (int i = 0; i < 256; i++) cycle(1'b1, 2'd3, 8'($urandom), 4'b1000);
      cycle(1'b0, 2'd0, 8'h00, 4'b1000);
      cycle(1'b0, 2'd0, 8'h00, 4'b0);
      @(negedge clk);
      chk("wrap_cnt", acc_cnt, 32'h0);

      // Reset with channels 0 and 2 holding words discards them.
      cycle(1'b1, 2'd0, 8'h5A, 4'b0);
      cycle(1'b1, 2'd2, 8'hC3, 4'b0);
      cycle(1'b0, 2'd0, 8'h00, 4'b0);
      @(negedge clk);
      chk("pre_rst_valid", 32'(out_valid), 32'h5);
      do_reset();
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", out_data, 32'h0);
      chk("mid_rst_cnt", acc_cnt, 32'h0);

      // Random traffic against the queue model.
      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 8'h00, 4'b1111);
      @(negedge clk);
      chk("final_drained", 32'(out_valid), 32'h0);

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
